// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Bundle of the fetch-stage bus signals. The master modport is
//               the fetch stage; the slave modport is everything around it
//               (instruction memory, decode, hazard/redirect control).
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        stall;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  stall,
    input  halt,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_inst,
    output if_pc,
    output if_pc_plus4,
    output fault,
    output fault_pc
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output stall,
    output halt,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_inst,
    input  if_pc,
    input  if_pc_plus4,
    input  fault,
    input  fault_pc
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : MIPS fetch stage. Owns the PC, drives the instruction memory
//               address and registers the returned word into a valid/ready
//               output register toward decode. Handles redirect, stall, halt.
//               Optional misaligned-redirect trap: define FETCH_ALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    st_run    = 2'd0,
    st_halted = 2'd1,
    st_fault  = 2'd2
  } state_t;

  localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_plus4;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_if_valid_nxt;
  logic [31:0] w_if_inst_nxt;
  logic [31:0] w_if_pc_nxt;
  logic [31:0] w_if_pc_plus4_nxt;

  logic        w_xfer;
  logic        w_cap;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_aligned;

`ifdef FETCH_ALIGN_CHK_EN
  logic        r_fault;
  logic [31:0] r_fault_pc;
  logic        w_fault_nxt;
  logic [31:0] w_fault_pc_nxt;
`endif

  // Handshake and capture qualifiers; a word is captured only while running.
  assign w_xfer             = r_if_valid & bus.if_ready;
  assign w_cap              = (r_state == st_run) & ~bus.stall & ~bus.redirect_valid
                              & (~r_if_valid | bus.if_ready);
  assign w_pc_plus4         = r_pc + 32'd4;
  assign w_redirect_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

  // Next-state / next-register logic; redirect outranks halt, stall and capture.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_valid_nxt    = r_if_valid;
    w_if_inst_nxt     = r_if_inst;
    w_if_pc_nxt       = r_if_pc;
    w_if_pc_plus4_nxt = r_if_pc_plus4;
`ifdef FETCH_ALIGN_CHK_EN
    w_fault_nxt       = r_fault;
    w_fault_pc_nxt    = r_fault_pc;
`endif
    if (bus.redirect_valid) begin
      // Flush the fetch register; any same-cycle handshake is already legal.
      w_if_valid_nxt = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        // Trap: PC stays where it was, offending target is recorded.
        w_state_nxt    = st_fault;
        w_fault_nxt    = 1'b1;
        w_fault_pc_nxt = bus.redirect_pc;
      end else begin
        w_state_nxt = st_run;
        w_pc_nxt    = w_redirect_aligned;
        w_fault_nxt = 1'b0;
      end
`else
      w_state_nxt = st_run;
      w_pc_nxt    = w_redirect_aligned;
`endif
    end else begin
      if (w_cap) begin
        w_if_inst_nxt     = bus.imem_inst;
        w_if_pc_nxt       = r_pc;
        w_if_pc_plus4_nxt = w_pc_plus4;
        w_if_valid_nxt    = 1'b1;
        w_pc_nxt          = w_pc_plus4;
      end else if (w_xfer) begin
        w_if_valid_nxt = 1'b0;
      end
      // The word captured alongside halt is the last one fetched.
      if ((r_state == st_run) && bus.halt) begin
        w_state_nxt = st_halted;
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= st_run;
      r_pc          <= c_reset_pc;
      r_if_valid    <= 1'b0;
      r_if_inst     <= 32'd0;
      r_if_pc       <= 32'd0;
      r_if_pc_plus4 <= 32'd4;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_if_inst     <= w_if_inst_nxt;
      r_if_pc       <= w_if_pc_nxt;
      r_if_pc_plus4 <= w_if_pc_plus4_nxt;
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  // Trap status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault    <= 1'b0;
      r_fault_pc <= 32'd0;
    end else begin
      r_fault    <= w_fault_nxt;
      r_fault_pc <= w_fault_pc_nxt;
    end
  end

  assign bus.fault    = r_fault;
  assign bus.fault_pc = r_fault_pc;
`else
  assign bus.fault    = 1'b0;
  assign bus.fault_pc = 32'd0;
`endif

  assign bus.imem_addr   = r_pc;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_inst     = r_if_inst;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_pc_plus4 = r_if_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch. A behavioural
//               model of the fetch stage is compared against the DUT on every
//               falling edge, and directed scenarios pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words, a hash everywhere else.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h2408_0005;
    if (a == 32'h4) return 32'h2409_0003;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_inst = memword(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4, m_fpc;
  logic        m_valid, m_halted, m_fault;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc     <= RESET_PC & ~32'd3;
      m_inst   <= 32'd0;
      m_ipc    <= 32'd0;
      m_ipc4   <= 32'd4;
      m_fpc    <= 32'd0;
      m_valid  <= 1'b0;
      m_halted <= 1'b0;
      m_fault  <= 1'b0;
    end else if (bus.redirect_valid) begin
      m_valid <= 1'b0;
      if (ALIGN_CHK && bus.redirect_pc[1:0] != 2'b00) begin
        m_fault <= 1'b1;
        m_fpc   <= bus.redirect_pc;
      end else begin
        m_pc     <= bus.redirect_pc & ~32'd3;
        m_halted <= 1'b0;
        m_fault  <= 1'b0;
      end
    end else if (!m_halted && !m_fault && !bus.stall && (!m_valid || bus.if_ready)) begin
      m_inst  <= memword(m_pc);
      m_ipc   <= m_pc;
      m_ipc4  <= m_pc + 32'd4;
      m_valid <= 1'b1;
      m_pc    <= m_pc + 32'd4;
      if (bus.halt) m_halted <= 1'b1;
    end else begin
      if (m_valid && bus.if_ready) m_valid <= 1'b0;
      if (bus.halt && !m_fault) m_halted <= 1'b1;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_imem_addr",   bus.imem_addr,        m_pc);
      chk("cmp_if_valid",    32'(bus.if_valid),    32'(m_valid));
      chk("cmp_if_inst",     bus.if_inst,          m_inst);
      chk("cmp_if_pc",       bus.if_pc,            m_ipc);
      chk("cmp_if_pc_plus4", bus.if_pc_plus4,      m_ipc4);
      chk("cmp_fault",       32'(bus.fault),       32'(m_fault));
      chk("cmp_fault_pc",    bus.fault_pc,         m_fpc);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst                = 1'b1;
    bus.stall          = 1'b0;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.if_ready       = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_if_valid",  32'(bus.if_valid), 32'd0);
    chk("rst_imem_addr", bus.imem_addr,     32'h0);
    chk("rst_if_pc",     bus.if_pc,         32'h0);
    chk("rst_if_inst",   bus.if_inst,       32'h0);
    chk("rst_pc_plus4",  bus.if_pc_plus4,   32'h4);
    chk("rst_fault",     32'(bus.fault),    32'd0);
    rst = 1'b0;

    // Basic fetch: one-cycle latency, one word per cycle.
    @(negedge clk);
    chk("t1_valid", 32'(bus.if_valid), 32'd1);
    chk("t1_inst",  bus.if_inst,       32'h2408_0005);
    chk("t1_pc",    bus.if_pc,         32'h0);
    chk("t1_addr",  bus.imem_addr,     32'h4);
    @(negedge clk);
    chk("t1_inst2", bus.if_inst,       32'h2409_0003);
    chk("t1_pc2",   bus.if_pc,         32'h4);

    // Backpressure: outputs frozen for three cycles.
    bus.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_pc",    bus.if_pc,         32'h4);
      chk("t2_inst",  bus.if_inst,       32'h2409_0003);
      chk("t2_valid", 32'(bus.if_valid), 32'd1);
      chk("t2_addr",  bus.imem_addr,     32'h8);
    end
    bus.if_ready = 1'b1;
    @(negedge clk);
    chk("t2_resume_pc", bus.if_pc, 32'h8);

    // Redirect beats stall and flushes.
    bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    @(negedge clk);
    chk("t3_valid", 32'(bus.if_valid), 32'd0);
    chk("t3_addr",  bus.imem_addr,     32'h40);
    bus.stall = 1'b0; bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_pc",    bus.if_pc,         32'h40);
    chk("t3_valid2", 32'(bus.if_valid), 32'd1);

    // Halt at pc 0x10: last word is 0x10, pc freezes at 0x14.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h10;
    @(negedge clk);
    bus.redirect_valid = 1'b0; bus.halt = 1'b1; bus.if_ready = 1'b0;
    @(negedge clk);
    bus.halt = 1'b0;
    chk("t4_addr",  bus.imem_addr,     32'h14);
    chk("t4_pc",    bus.if_pc,         32'h10);
    chk("t4_valid", 32'(bus.if_valid), 32'd1);
    @(negedge clk);
    chk("t4_hold_valid", 32'(bus.if_valid), 32'd1);
    bus.if_ready = 1'b1;
    @(negedge clk);
    chk("t4_drain_valid", 32'(bus.if_valid), 32'd0);
    chk("t4_frozen_addr", bus.imem_addr,     32'h14);
    @(negedge clk);
    chk("t4_still_frozen", bus.imem_addr, 32'h14);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("t4_redir_addr", bus.imem_addr, 32'h100);
    @(negedge clk);
    chk("t4_resume_pc", bus.if_pc, 32'h100);

    // Misaligned redirect.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h42;
    @(negedge clk);
`ifdef FETCH_ALIGN_CHK_EN
    chk("t5_fault",    32'(bus.fault),    32'd1);
    chk("t5_fault_pc", bus.fault_pc,      32'h42);
    chk("t5_valid",    32'(bus.if_valid), 32'd0);
    chk("t5_pc_kept",  bus.imem_addr,     32'h104);
    bus.redirect_pc = 32'h46;
    @(negedge clk);
    chk("t5_fault_pc2", bus.fault_pc,   32'h46);
    chk("t5_fault2",    32'(bus.fault), 32'd1);
    bus.redirect_pc = 32'h80;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("t5_clear", 32'(bus.fault), 32'd0);
    @(negedge clk);
    chk("t5_pc", bus.if_pc, 32'h80);
`else
    bus.redirect_valid = 1'b0;
    chk("t5_addr",  bus.imem_addr,   32'h40);
    chk("t5_fault", 32'(bus.fault),  32'd0);
    @(negedge clk);
    chk("t5_pc",    bus.if_pc,       32'h40);
`endif

    // PC wrap at the top of the address space.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("t6_wrap_pc",    bus.if_pc,       32'hFFFF_FFFC);
    chk("t6_wrap_plus4", bus.if_pc_plus4, 32'h0);
    chk("t6_wrap_addr",  bus.imem_addr,   32'h0);

    // Mixed traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 60; i++) begin
      bus.if_ready       = ($urandom_range(0, 3) != 0);
      bus.stall          = ($urandom_range(0, 4) == 0);
      bus.halt           = ($urandom_range(0, 9) == 0);
      bus.redirect_valid = ($urandom_range(0, 6) == 0);
      bus.redirect_pc    = 32'($urandom_range(0, 1023));
      @(negedge clk);
    end

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_valid", 32'(bus.if_valid), 32'd0);
    chk("t6_arst_addr",  bus.imem_addr,     RESET_PC);
    chk("t6_arst_plus4", bus.if_pc_plus4,   32'h4);
    chk("t6_arst_fault", 32'(bus.fault),    32'd0);
    bus.stall = 1'b0; bus.halt = 1'b0; bus.redirect_valid = 1'b0; bus.if_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_restart_pc", bus.if_pc, 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
